// File: rtl/processor_pkg.sv
// Shared processor types and defaults: datapath widths, reset PC and the fetch FSM encoding.
package processor_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_INST_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: redirect load has priority over the sequential increment.
module fetch_pc_reg #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadPC,
  input  logic              incEn,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (loadEn) begin
      pc <= loadPC;
    end else if (incEn) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding imem request, branch squash, valid/stall output register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import processor_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int INST_W = DEFAULT_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isBranchTaken,
  input  logic [ADDR_W-1:0] branchPC,
  input  logic              stall,
  output logic              imemReqValid,
  input  logic              imemReqReady,
  output logic [ADDR_W-1:0] imemReqAddr,
  input  logic              imemRespValid,
  input  logic [INST_W-1:0] imemRespData,
  output logic              ifValid,
  output logic [INST_W-1:0] ifInst,
  output logic [ADDR_W-1:0] ifPC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perfFetched,
  output logic [31:0]       perfKilled
`endif
);

  fetch_state_t state, stateNext;
  logic kill, killNext;
  logic [ADDR_W-1:0] pc;
  logic slotFree;
  logic reqFire;
  logic accept;
  logic drop;

  fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) pcReg (
    .clk   (clk),
    .rst   (rst),
    .loadEn(isBranchTaken),
    .loadPC(branchPC),
    .incEn (accept),
    .pc    (pc)
  );

  // Requests only go out when the output slot can take the answer, so no skid buffer is needed.
  assign slotFree    = !ifValid || !stall;
  assign imemReqAddr = pc;

  always_comb begin
    stateNext    = state;
    killNext     = kill;
    imemReqValid = 1'b0;
    reqFire      = 1'b0;
    accept       = 1'b0;
    drop         = 1'b0;
    case (state)
      FETCH: begin
        imemReqValid = slotFree && !rst;
        reqFire      = imemReqValid && imemReqReady;
        if (reqFire) begin
          stateNext = WAIT;
          if (isBranchTaken) killNext = 1'b1;
        end
      end
      WAIT: begin
        if (imemRespValid) begin
          stateNext = FETCH;
          killNext  = 1'b0;
          if (kill || isBranchTaken) drop = 1'b1;
          else accept = 1'b1;
        end else if (isBranchTaken) begin
          killNext = 1'b1;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      kill  <= 1'b0;
    end else begin
      state <= stateNext;
      kill  <= killNext;
    end
  end

  // A redirect flushes the output register even when downstream is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifValid <= 1'b0;
      ifInst  <= '0;
      ifPC    <= '0;
    end else if (isBranchTaken) begin
      ifValid <= 1'b0;
    end else if (accept) begin
      ifValid <= 1'b1;
      ifInst  <= imemRespData;
      ifPC    <= pc;
    end else if (ifValid && !stall) begin
      ifValid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic killEvent;

  // A discarded response and a flushed slot in the same cycle count once.
  assign killEvent = drop || (isBranchTaken && ifValid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfFetched <= '0;
      perfKilled  <= '0;
    end else begin
      if (accept)    perfFetched <= perfFetched + 32'd1;
      if (killEvent) perfKilled  <= perfKilled + 32'd1;
    end
  end
`else
  logic unusedDrop;
  assign unusedDrop = drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency returning 0xA0+addr.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        isBranchTaken;
  logic [31:0] branchPC;
  logic        stall;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        ifValid;
  logic [31:0] ifInst;
  logic [31:0] ifPC;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetched;
  logic [31:0] perfKilled;
`endif

  int checkCount = 0;
  int passCount  = 0;

  // Memory model state
  logic        memPend = 1'b0;
  int          memCnt  = 0;
  int          memLat  = 1;
  logic [31:0] memAddr = '0;
  logic        spurious = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .isBranchTaken(isBranchTaken),
    .branchPC     (branchPC),
    .stall        (stall),
    .imemReqValid (imemReqValid),
    .imemReqReady (imemReqReady),
    .imemReqAddr  (imemReqAddr),
    .imemRespValid(imemRespValid),
    .imemRespData (imemRespData),
    .ifValid      (ifValid),
    .ifInst       (ifInst),
    .ifPC         (ifPC)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perfFetched  (perfFetched),
    .perfKilled   (perfKilled)
`endif
  );

  always @(posedge clk) begin
    if (memPend) begin
      if (memCnt == 1) memPend <= 1'b0;
      else memCnt <= memCnt - 1;
    end
    if (imemReqValid && imemReqReady) begin
      memPend <= 1'b1;
      memCnt  <= memLat;
      memAddr <= imemReqAddr;
    end
  end

  assign imemRespValid = (memPend && memCnt == 1) || spurious;
  assign imemRespData  = memAddr + 32'h0000_00A0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
      $display("ok   %s = %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic [31:0] pcExp, input logic [31:0] instExp);
    checkVal({tag, ".ifValid"}, {31'd0, ifValid}, 32'd1);
    checkVal({tag, ".ifPC"}, ifPC, pcExp);
    checkVal({tag, ".ifInst"}, ifInst, instExp);
  endtask

  initial begin
    rst = 1'b1;
    isBranchTaken = 1'b0;
    branchPC = '0;
    stall = 1'b0;
    imemReqReady = 1'b1;
    tick();
    tick();
    checkVal("rst.reqValid", {31'd0, imemReqValid}, 32'd0);
    checkVal("rst.ifValid", {31'd0, ifValid}, 32'd0);
    checkVal("rst.ifInst", ifInst, 32'd0);
    checkVal("rst.ifPC", ifPC, 32'd0);
    rst = 1'b0;
    #1;

    // Sequential fetch, zero-wait memory
    checkVal("seq0.reqValid", {31'd0, imemReqValid}, 32'd1);
    checkVal("seq0.reqAddr", imemReqAddr, 32'h0);
    tick();
    checkVal("seq0.wait.reqValid", {31'd0, imemReqValid}, 32'd0);
    tick();
    checkOut("seq0", 32'h0, 32'hA0);
    checkVal("seq1.reqAddr", imemReqAddr, 32'h4);
    tick();
    checkVal("seq0.consumed", {31'd0, ifValid}, 32'd0);
    tick();
    checkOut("seq1", 32'h4, 32'hA4);

    // Stall holds the output register and blocks new requests
    stall = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkVal("stall.reqValid", {31'd0, imemReqValid}, 32'd0);
      tick();
      checkOut("stall", 32'h4, 32'hA4);
    end
    checkVal("stall.reqValidHeld", {31'd0, imemReqValid}, 32'd0);
    stall = 1'b0;
    #1;
    checkVal("unstall.reqValid", {31'd0, imemReqValid}, 32'd1);
    checkVal("unstall.reqAddr", imemReqAddr, 32'h8);
    tick();
    tick();
    checkOut("seq2", 32'h8, 32'hA8);
    checkVal("seq3.reqAddr", imemReqAddr, 32'hC);

    // Latency 3, redirect in the second wait cycle
    memLat = 3;
    tick();
    tick();
    isBranchTaken = 1'b1;
    branchPC = 32'h100;
    tick();
    isBranchTaken = 1'b0;
    checkVal("lat3.staleResp.ifValid", {31'd0, ifValid}, 32'd0);
    checkVal("lat3.staleResp.reqValid", {31'd0, imemReqValid}, 32'd0);
    memLat = 1;
    tick();
    checkVal("lat3.dropped.ifValid", {31'd0, ifValid}, 32'd0);
    checkVal("lat3.reqValid", {31'd0, imemReqValid}, 32'd1);
    checkVal("lat3.reqAddr", imemReqAddr, 32'h100);
    tick();
    checkVal("lat3.wait.ifValid", {31'd0, ifValid}, 32'd0);
    tick();
    checkOut("redir100", 32'h100, 32'h1A0);
    checkVal("redir100.nextAddr", imemReqAddr, 32'h104);

    // Redirect without a handshake, then redirect coincident with a handshake
    imemReqReady = 1'b0;
    tick();
    checkVal("noHs.ifValid", {31'd0, ifValid}, 32'd0);
    isBranchTaken = 1'b1;
    branchPC = 32'h8;
    tick();
    isBranchTaken = 1'b0;
    imemReqReady = 1'b1;
    #1;
    checkVal("noHs.reqAddr", imemReqAddr, 32'h8);
    isBranchTaken = 1'b1;
    branchPC = 32'h40;
    tick();
    isBranchTaken = 1'b0;
    checkVal("coinc.reqValid", {31'd0, imemReqValid}, 32'd0);
    tick();
    checkVal("coinc.dropped.ifValid", {31'd0, ifValid}, 32'd0);
    checkVal("coinc.reqAddr", imemReqAddr, 32'h40);
    tick();
    tick();
    checkOut("redir40", 32'h40, 32'hE0);

    // Redirect while stalled flushes the output register
    stall = 1'b1;
    isBranchTaken = 1'b1;
    branchPC = 32'h200;
    tick();
    isBranchTaken = 1'b0;
    checkVal("flush.ifValid", {31'd0, ifValid}, 32'd0);
    checkVal("flush.reqAddr", imemReqAddr, 32'h200);
    stall = 1'b0;
    tick();
    tick();
    checkOut("redir200", 32'h200, 32'h2A0);

    // PC wrap
    imemReqReady = 1'b0;
    tick();
    isBranchTaken = 1'b1;
    branchPC = 32'hFFFF_FFFC;
    tick();
    isBranchTaken = 1'b0;
    imemReqReady = 1'b1;
    #1;
    checkVal("wrap.reqAddr", imemReqAddr, 32'hFFFF_FFFC);
    tick();
    tick();
    checkOut("wrap", 32'hFFFF_FFFC, 32'h0000_009C);
    checkVal("wrap.nextAddr", imemReqAddr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkVal("perf.fetched", perfFetched, 32'd7);
    checkVal("perf.killed", perfKilled, 32'd3);
`endif

    // Reset mid-request: the late response must be ignored
    memLat = 3;
    tick();
    rst = 1'b1;
    #1;
    checkVal("midRst.reqValid", {31'd0, imemReqValid}, 32'd0);
    checkVal("midRst.ifValid", {31'd0, ifValid}, 32'd0);
    tick();
    imemReqReady = 1'b0;
    rst = 1'b0;
    tick();
    checkVal("lateResp.present", {31'd0, imemRespValid}, 32'd1);
    tick();
    checkVal("lateResp.ifValid", {31'd0, ifValid}, 32'd0);
    checkVal("lateResp.reqAddr", imemReqAddr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkVal("perf.rstFetched", perfFetched, 32'd0);
    checkVal("perf.rstKilled", perfKilled, 32'd0);
`endif

    // Spurious response in FETCH
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    checkVal("spur.ifValid", {31'd0, ifValid}, 32'd0);
    checkVal("spur.reqAddr", imemReqAddr, 32'h0);
    memLat = 1;
    imemReqReady = 1'b1;
    tick();
    tick();
    checkOut("postRst", 32'h0, 32'hA0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
